// File: rtl/lighthouse_ootx_decoder_if.sv
// Bit-stream input and decoded-frame output bundle for the lighthouse OOTX decoder.
// master drives OOTX bits and observes frames; slave is the decoder itself.
interface lighthouse_ootx_decoder_if;
    logic        bit_strobe;
    logic        bit_data;
    logic        bit_lighthouse;
    logic        frame_start;
    logic [15:0] length;
    logic        byte_strobe;
    logic [7:0]  payload_byte;
    logic        frame_done;
    logic        frame_ok;
    logic        error;

    modport master (
        output bit_strobe, bit_data, bit_lighthouse,
        input  frame_start, length, byte_strobe, payload_byte, frame_done, frame_ok, error
    );

    modport slave (
        input  bit_strobe, bit_data, bit_lighthouse,
        output frame_start, length, byte_strobe, payload_byte, frame_done, frame_ok, error
    );
endinterface

// File: rtl/lighthouse_ootx_decoder.sv
// Reassembles one lighthouse's OOTX frame: preamble hunt, length, payload bytes, CRC32 check.
// Define OOTX_CRC_EN to build the CRC32 engine; otherwise frame_ok reads 1 on every frame_done.
module lighthouse_ootx_decoder #(
    parameter int LIGHTHOUSE     = 0,
    parameter int MAX_LEN        = 64,
    parameter int PREAMBLE_ZEROS = 17
) (
    input logic                       clk,
    input logic                       reset_n,
    lighthouse_ootx_decoder_if.slave  bus
);
    localparam logic        LH_BIT = 1'(LIGHTHOUSE);
    localparam logic [15:0] MAX_L  = 16'(MAX_LEN);
    localparam logic [4:0]  PRE_Z  = 5'(PREAMBLE_ZEROS);

    typedef enum logic [2:0] {
        HUNT, LEN, LEN_SYNC, PAYLOAD, PAY_SYNC, CRC, CRC_SYNC
    } state_t;

    state_t      state;
    logic [4:0]  zero_run;
    logic [3:0]  bit_cnt;
    logic [15:0] word;
    logic [15:0] byte_idx;
    logic        crc_word;

    logic        frame_start_q;
    logic [15:0] length_q;
    logic        byte_strobe_q;
    logic [7:0]  payload_byte_q;
    logic        frame_done_q;
    logic        frame_ok_q;
    logic        error_q;

    logic        ev;
    logic [15:0] w_next;
    logic [15:0] len_w;

    assign ev     = bus.bit_strobe && (bus.bit_lighthouse == LH_BIT);
    assign w_next = {word[14:0], bus.bit_data};
    // Length travels little-endian inside a big-endian word.
    assign len_w  = {word[7:0], word[15:8]};

`ifdef OOTX_CRC_EN
    localparam logic [31:0] POLY = 32'hEDB88320;
    logic [31:0] crc;
    logic [31:0] crc_sh;
    logic [31:0] rx_crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    // crc_sh holds b0..b3 MSB-first once the second CRC word has shifted in.
    assign rx_crc = {crc_sh[7:0], crc_sh[15:8], crc_sh[23:16], crc_sh[31:24]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HUNT;
            zero_run       <= '0;
            bit_cnt        <= '0;
            word           <= '0;
            byte_idx       <= '0;
            crc_word       <= 1'b0;
            frame_start_q  <= 1'b0;
            length_q       <= '0;
            byte_strobe_q  <= 1'b0;
            payload_byte_q <= '0;
            frame_done_q   <= 1'b0;
            frame_ok_q     <= 1'b0;
            error_q        <= 1'b0;
`ifdef OOTX_CRC_EN
            crc            <= '1;
            crc_sh         <= '0;
`endif
        end else begin
            frame_start_q <= 1'b0;
            byte_strobe_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            if (ev) begin
                if (bus.bit_data)
                    zero_run <= '0;
                else if (zero_run != 5'd31)
                    zero_run <= zero_run + 5'd1;

                case (state)
                    HUNT: begin
                        if (bus.bit_data && zero_run >= PRE_Z) begin
                            bit_cnt <= '0;
                            state   <= LEN;
                        end
                    end
                    LEN: begin
                        word    <= w_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15)
                            state <= LEN_SYNC;
                    end
                    LEN_SYNC: begin
                        if (!bus.bit_data || len_w > MAX_L) begin
                            error_q <= 1'b1;
                            state   <= HUNT;
                        end else begin
                            bit_cnt  <= '0;
                            byte_idx <= '0;
                            crc_word <= 1'b0;
`ifdef OOTX_CRC_EN
                            crc      <= '1;
`endif
                            if (len_w == 16'd0) begin
                                state <= CRC;
                            end else begin
                                frame_start_q <= 1'b1;
                                length_q      <= len_w;
                                state         <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        word    <= w_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt[2:0] == 3'd7) begin
                            byte_idx <= byte_idx + 16'd1;
                            // The pad byte of an odd-length payload is dropped here.
                            if (byte_idx < length_q) begin
                                byte_strobe_q  <= 1'b1;
                                payload_byte_q <= w_next[7:0];
`ifdef OOTX_CRC_EN
                                crc            <= crc32_byte(crc, w_next[7:0]);
`endif
                            end
                        end
                        if (bit_cnt == 4'd15)
                            state <= PAY_SYNC;
                    end
                    PAY_SYNC: begin
                        if (!bus.bit_data) begin
                            error_q <= 1'b1;
                            state   <= HUNT;
                        end else begin
                            bit_cnt <= '0;
                            state   <= (byte_idx >= length_q) ? CRC : PAYLOAD;
                        end
                    end
                    CRC: begin
                        bit_cnt <= bit_cnt + 4'd1;
`ifdef OOTX_CRC_EN
                        crc_sh  <= {crc_sh[30:0], bus.bit_data};
`endif
                        if (bit_cnt == 4'd15)
                            state <= CRC_SYNC;
                    end
                    CRC_SYNC: begin
                        if (!bus.bit_data) begin
                            error_q <= 1'b1;
                            state   <= HUNT;
                        end else if (!crc_word) begin
                            crc_word <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= CRC;
                        end else begin
                            frame_done_q <= 1'b1;
`ifdef OOTX_CRC_EN
                            frame_ok_q   <= (rx_crc == ~crc);
`else
                            frame_ok_q   <= 1'b1;
`endif
                            state        <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.frame_start  = frame_start_q;
    assign bus.length       = length_q;
    assign bus.byte_strobe  = byte_strobe_q;
    assign bus.payload_byte = payload_byte_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_ok     = frame_ok_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Directed OOTX frames with a scoreboard of expected decoder events.
module tb_lighthouse_ootx_decoder;
    localparam int LH   = 0;
    localparam int MAXL = 64;
    localparam int K_START = 0, K_BYTE = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lighthouse_ootx_decoder_if bus();

    lighthouse_ootx_decoder #(
        .LIGHTHOUSE(LH), .MAX_LEN(MAXL), .PREAMBLE_ZEROS(17)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    ev_t        q[$];
    int         total = 0;
    int         bad = 0;
    bit         interleave = 1'b0;
    logic [7:0] pl [64];
    logic       last_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic see(input int kind, input logic [15:0] val, input string tag);
        ev_t e;
        if (q.size() == 0) begin
            chk({"unexpected_", tag}, 32'(kind), 32'hFFFF_FFFF);
            return;
        end
        e = q.pop_front();
        chk({"kind_", tag}, 32'(kind), 32'(e.kind));
        if (kind == e.kind) chk(tag, {16'h0, val}, {16'h0, e.val});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.frame_start) see(K_START, bus.length, "frame_start_length");
            if (bus.byte_strobe) see(K_BYTE, {8'h0, bus.payload_byte}, "payload_byte");
            if (bus.frame_done)  see(K_DONE, {15'h0, bus.frame_ok}, "frame_ok");
            if (bus.error)       see(K_ERR, 16'h0, "error");
        end
    end

    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, pl[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic send_bit(input logic b);
        bus.bit_strobe = 1'b1; bus.bit_data = b; bus.bit_lighthouse = 1'(LH);
        @(posedge clk); #1;
        if (interleave) begin
            bus.bit_data = 1'($urandom_range(0, 1)); bus.bit_lighthouse = ~1'(LH);
            @(posedge clk); #1;
        end
        bus.bit_strobe = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic sync);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        send_bit(sync);
    endtask

    task automatic preamble();
        for (int i = 0; i < 17; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    // flip >= 0 corrupts that CRC bit; bad_word >= 0 sends a 0 sync after that payload word.
    task automatic send_frame(input int len, input int flip, input int bad_word);
        logic [31:0] crc;
        logic [7:0]  hi, lo;
        logic        ok;
        preamble();
        if (len > MAXL) q.push_back('{K_ERR, 16'h0});
        else if (len != 0) q.push_back('{K_START, 16'(len)});
        send_word({8'(len), 8'(len >> 8)}, 1'b1);
        if (len > MAXL) return;
        for (int w = 0; w < (len + 1) / 2; w++) begin
            hi = pl[2*w];
            lo = (2*w + 1 < len) ? pl[2*w+1] : 8'h00;
            q.push_back('{K_BYTE, {8'h0, hi}});
            if (2*w + 1 < len) q.push_back('{K_BYTE, {8'h0, lo}});
            if (w == bad_word) q.push_back('{K_ERR, 16'h0});
            send_word({hi, lo}, w != bad_word);
            if (w == bad_word) return;
        end
        crc = crc32(len);
        if (flip >= 0) crc[flip] = ~crc[flip];
`ifdef OOTX_CRC_EN
        ok = (flip < 0);
`else
        ok = 1'b1;
`endif
        last_ok = ok;
        q.push_back('{K_DONE, {15'h0, ok}});
        send_word({crc[7:0], crc[15:8]}, 1'b1);
        send_word({crc[23:16], crc[31:24]}, 1'b1);
    endtask

    task automatic settle(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.frame_start, bus.byte_strobe, bus.frame_done, bus.frame_ok, bus.error,
                  bus.payload_byte, bus.length}, 32'h0);
    endtask

    initial begin
        bus.bit_strobe = 1'b0; bus.bit_data = 1'b0; bus.bit_lighthouse = 1'b0;
        last_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // 16 zeros then 1 must not start a frame; the following good frame must decode.
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        send_bit(1'b1);
        pl[0] = 8'hAB; pl[1] = 8'hCD;
        send_frame(2, -1, -1);
        settle("frame_len2_drained");

        send_frame(2, 5, -1);
        settle("frame_badcrc_drained");
        chk("frame_ok_hold", 32'(bus.frame_ok), 32'(last_ok));
        chk("length_hold", 32'(bus.length), 32'd2);

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, -1, -1);
        settle("frame_len3_drained");

        pl[0] = 8'hAB; pl[1] = 8'hCD;
        send_frame(2, -1, 0);
        settle("bad_sync_drained");
        send_frame(2, -1, -1);
        settle("after_bad_sync_drained");

        send_frame(65, -1, -1);
        settle("len_too_big_drained");
        chk("len_too_big_no_start_length", 32'(bus.length), 32'd2);
        send_frame(0, -1, -1);
        settle("len_zero_drained");
        pl[0] = 8'h5E; pl[1] = 8'hA7; pl[2] = 8'h01; pl[3] = 8'hFE;
        send_frame(4, -1, -1);
        settle("len4_drained");

        // Foreign-lighthouse bits interleaved, then reset mid-payload.
        interleave = 1'b1;
        pl[0] = 8'hAB; pl[1] = 8'hCD;
        preamble();
        q.push_back('{K_START, 16'd2});
        send_word(16'h0200, 1'b1);
        q.push_back('{K_BYTE, 16'h00AB});
        for (int i = 7; i >= 0; i--) send_bit(pl[0][i]);
        @(negedge clk); #1;
        chk("pre_reset_queue", 32'(q.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midframe_reset_outputs");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, -1, -1);
        settle("post_reset_frame_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
